// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// Latency: none (types only).
// Backpressure: none.
package sar_pkg;
  localparam int SAR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    DONE
  } state_t;
endpackage

// File: rtl/sar_step.sv
// One SAR trial step: resolves guess bit idx from the flags and arms the next bit.
// Latency: combinational.
// Backpressure: none.
module sar_step
  import sar_pkg::*;
#(
  parameter int W  = SAR_W,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  guess,
  input  logic [IW-1:0] idx,
  input  logic          cmp_lt,
  input  logic          cmp_eq,
  input  logic          cmp_gt,
  output logic [W-1:0]  next_guess,
  output logic          flag_ok,
  output logic          last
);

  always_comb begin
    flag_ok    = $onehot({cmp_lt, cmp_eq, cmp_gt});
    last       = (idx == '0);
    next_guess = guess;
    // Invalid flag combinations resolve the bit as "target below guess".
    next_guess[idx] = flag_ok & (cmp_gt | cmp_eq);
    if (!last) begin
      next_guess[idx - 1'b1] = 1'b1;
    end
  end

endmodule

// File: rtl/sar_search4.sv
// MSB-first SAR search driving comparator operand b; SAR_EARLY_EXIT_EN stops on equal.
// Latency: start to done W+1 cycles (2..W+1 with SAR_EARLY_EXIT_EN).
// Backpressure: none; start is only sampled in IDLE and is never queued.
module sar_search4
  import sar_pkg::*;
#(
  parameter int W = SAR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_lt,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  output logic [W-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]  MSB_ONLY = {1'b1, {(W-1){1'b0}}};
  localparam logic [IW-1:0] TOP_IDX  = IW'(W - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  next_guess;
  logic          flag_ok;
  logic          last;

  sar_step #(.W(W), .IW(IW)) u_step (
    .guess      (guess),
    .idx        (idx),
    .cmp_lt     (cmp_lt),
    .cmp_eq     (cmp_eq),
    .cmp_gt     (cmp_gt),
    .next_guess (next_guess),
    .flag_ok    (flag_ok),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= TOP_IDX;
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= TRIAL;
            guess <= MSB_ONLY;
            idx   <= TOP_IDX;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        TRIAL: begin
          if (!flag_ok) begin
            err <= 1'b1;
          end
`ifdef SAR_EARLY_EXIT_EN
          if (flag_ok && cmp_eq) begin
            result <= guess;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            guess  <= '0;
          end else
`endif
          if (last) begin
            result <= next_guess;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            guess  <= '0;
          end else begin
            guess <= next_guess;
            idx   <= idx - 1'b1;
          end
        end
        DONE: begin
          // Single-cycle done pulse; a start seen here is deliberately dropped.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search4.sv
// Bench for sar_search4: behavioural comparator plus binary-search reference model.
module tb_sar_search4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         cmp_lt, cmp_eq, cmp_gt;
  logic [W-1:0] guess, result;
  logic         busy, done, err;

  logic [W-1:0] tgt = '0;
  logic         force_bad = 1'b0;
  logic [2:0]   bad_flags = 3'b000;
  logic [W-1:0] last_result = '0;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  // Comparator: operand a is the hidden target, operand b is the DUT guess.
  always_comb begin
    if (force_bad) begin
      {cmp_lt, cmp_eq, cmp_gt} = bad_flags;
    end else begin
      cmp_lt = (tgt < guess);
      cmp_eq = (tgt == guess);
      cmp_gt = (tgt > guess);
    end
  end

  sar_search4 #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full search of target t; trial bad_k (-1 for none) sees flag pattern bad_pat.
  task automatic search(input logic [W-1:0] t, input int bad_k, input logic [2:0] bad_pat,
                        input string name);
    logic [W-1:0] acc, trial;
    logic         exp_err, hit;
    acc = '0;
    exp_err = 1'b0;
    hit = 1'b0;
    tgt = t;
    start = 1'b1;
    tick;
    start = 1'b0;
    vectors++;
    if (result !== last_result) begin
      miscompares++;
      $display("FAIL %s result_hold: got %0d want %0d", name, result, last_result);
    end
    for (int k = W - 1; k >= 0; k--) begin
      trial = acc | (4'b0001 << k);
      vectors++;
      if (guess !== trial || busy !== 1'b1 || done !== 1'b0 || err !== exp_err) begin
        miscompares++;
        $display("FAIL %s trial%0d: guess=%0d busy=%b done=%b err=%b want guess=%0d busy=1 done=0 err=%b",
                 name, k, guess, busy, done, err, trial, exp_err);
      end
      force_bad = (k == bad_k);
      bad_flags = bad_pat;
      if (k == bad_k) begin
        exp_err = 1'b1;
      end else if (t >= trial) begin
        acc = trial;
      end
`ifdef SAR_EARLY_EXIT_EN
      if (k != bad_k && t == trial) hit = 1'b1;
`endif
      tick;
      force_bad = 1'b0;
      if (hit) break;
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || guess !== '0 || result !== acc || err !== exp_err) begin
      miscompares++;
      $display("FAIL %s done_cycle: done=%b busy=%b guess=%0d result=%0d err=%b want 1 0 0 %0d %b",
               name, done, busy, guess, result, err, acc, exp_err);
    end
    last_result = acc;
    tick;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== acc) begin
      miscompares++;
      $display("FAIL %s after_done: done=%b busy=%b result=%0d want 0 0 %0d",
               name, done, busy, result, acc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    tick;
    tick;
    vectors++;
    if (guess !== '0 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: guess=%0d busy=%b done=%b result=%0d err=%b want all zero",
               guess, busy, done, result, err);
    end
    rst = 1'b0;
    start = 1'b0;
    last_result = '0;
    tick;
    vectors++;
    if (busy !== 1'b0 || guess !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b guess=%0d want 0 0", busy, guess);
    end
  endtask

  task automatic test_directed;
    search(4'd11, -1, 3'b000, "t11");
    search(4'd0,  -1, 3'b000, "t0");
    search(4'd15, -1, 3'b000, "t15");
    search(4'd8,  -1, 3'b000, "t8");
    search(4'd3,  -1, 3'b000, "t3");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      search(4'($urandom_range(0, 15)), -1, 3'b000, "rand");
    end
  endtask

  task automatic test_err;
    logic [2:0] pats [5] = '{3'b101, 3'b000, 3'b111, 3'b110, 3'b011};
    search(4'd9, 2, 3'b101, "err9");
    search(4'd9, -1, 3'b000, "err_clear");
    for (int i = 0; i < 8; i++) begin
      search(4'($urandom_range(0, 15)), $urandom_range(0, W - 1), pats[$urandom_range(0, 4)],
             "err_rand");
    end
  endtask

  task automatic test_back_to_back;
    int cyc, prev, guard;
    tgt = 4'd5;
    start = 1'b1;
    tick;
    cyc = 1;
    prev = 0;
    for (int n = 0; n < 3; n++) begin
      guard = 0;
      while (done !== 1'b1 && guard < 40) begin
        tick;
        cyc++;
        guard++;
      end
      vectors++;
      if (done !== 1'b1 || cyc != (n == 0 ? 5 : prev + 6) || result !== 4'd5) begin
        miscompares++;
        $display("FAIL held_start%0d: done=%b cycle=%0d result=%0d want done=1 cycle=%0d result=5",
                 n, done, cyc, result, (n == 0 ? 5 : prev + 6));
      end
      prev = cyc;
      tick;
      cyc++;
    end
    start = 1'b0;
    last_result = 4'd5;
    tick;
    tick;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL held_release: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    search(4'd13, -1, 3'b000, "pre_rst");
    tgt = 4'd6;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if (guess !== '0 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: guess=%0d busy=%b done=%b result=%0d err=%b want all zero",
               guess, busy, done, result, err);
    end
    last_result = '0;
    for (int i = 0; i < 6; i++) begin
      tick;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_quiet%0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    search(4'd6, -1, 3'b000, "post_rst");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_err;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
